// File: rtl/obj_scheduler_if.sv
// Spawn/collide handshake and slot words between game logic and the object scheduler.
interface obj_scheduler_if;
    logic        spawn_req;
    logic [1:0]  spawn_type;
    logic [9:0]  spawn_vpos;
    logic        spawn_ack;
    logic        spawn_drop;
    logic [4:0]  collide;
    logic [25:0] p_obj1;
    logic [25:0] p_obj2;
    logic [25:0] p_obj3;
    logic [25:0] p_obj4;
    logic [25:0] p_obj5;
    logic        busy;

    modport master (
        output spawn_req, spawn_type, spawn_vpos, collide,
        input  spawn_ack, spawn_drop, p_obj1, p_obj2, p_obj3, p_obj4, p_obj5, busy
    );

    modport slave (
        input  spawn_req, spawn_type, spawn_vpos, collide,
        output spawn_ack, spawn_drop, p_obj1, p_obj2, p_obj3, p_obj4, p_obj5, busy
    );
endinterface

// File: rtl/obj_scheduler.sv
// Five-slot sprite scheduler: allocates spawns, clears collisions and sweeps the
// slots once per frame (scroll left, animate, retire off-screen objects).
module obj_scheduler #(
    parameter int SPAWN_X    = 1009,
    parameter int NUM_FRAMES = 6,
    parameter int ANIM_DIV   = 4
) (
    input  logic       vclock,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic [3:0] scroll_speed,
    obj_scheduler_if.slave bus
);
    localparam int            AW         = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [AW-1:0] ANIM_LAST  = AW'(ANIM_DIV - 1);
    localparam logic [2:0]    FRAME_LAST = 3'(NUM_FRAMES - 1);
    localparam logic [10:0]   SPAWN_H    = 11'(SPAWN_X);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sidx_q, sidx_d;
    logic          vsync_d_q, vsync_d_d;
    logic [AW-1:0] anim_q, anim_d;
    logic          step_q, step_d;
    logic          ack_q, ack_d;
    logic          drop_q, drop_d;
    logic          busy_q, busy_d;
    // Slot word doubles as the valid flag: hpos is kept >= 1 while occupied.
    logic [25:0]   slot_q [5];
    logic [25:0]   slot_d [5];

    logic          tick;
    logic          found;
    logic [10:0]   speed_ext;

    assign tick      = vsync_d_q & ~vsync;
    assign speed_ext = {7'b0, scroll_speed};

    always_comb begin
        state_d   = state_q;
        sidx_d    = sidx_q;
        vsync_d_d = vsync;
        anim_d    = anim_q;
        step_d    = step_q;
        ack_d     = 1'b0;
        drop_d    = 1'b0;
        busy_d    = busy_q;
        slot_d    = slot_q;
        found     = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SWEEP;
                    sidx_d  = 3'd0;
                    busy_d  = 1'b1;
                    if (anim_q == ANIM_LAST) begin
                        anim_d = '0;
                        step_d = 1'b1;
                    end else begin
                        anim_d = anim_q + 1'b1;
                        step_d = 1'b0;
                    end
                end else if (bus.spawn_req && !ack_q && (bus.collide == 5'd0)) begin
                    // ack_q gate keeps the still-high request in the ack cycle from spawning twice.
                    ack_d = 1'b1;
                    for (int i = 0; i < 5; i++) begin
                        if (!found && (slot_q[i][20:10] == 11'd0)) begin
                            found     = 1'b1;
                            slot_d[i] = {3'd0, bus.spawn_type, SPAWN_H, bus.spawn_vpos};
                        end
                    end
                    drop_d = !found;
                end
            end
            SWEEP: begin
                for (int i = 0; i < 5; i++) begin
                    if ((sidx_q == 3'(i)) && (slot_q[i][20:10] != 11'd0)) begin
                        if (slot_q[i][20:10] <= speed_ext) begin
                            slot_d[i] = '0;
                        end else begin
                            slot_d[i][20:10] = slot_q[i][20:10] - speed_ext;
                            if (step_q) begin
                                slot_d[i][25:23] = (slot_q[i][25:23] == FRAME_LAST) ?
                                                   3'd0 : slot_q[i][25:23] + 3'd1;
                            end
                        end
                    end
                end
                if (sidx_q == 3'd4) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    sidx_d = sidx_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < 5; i++) begin
            if (bus.collide[i]) slot_d[i] = '0;
        end
    end

    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sidx_q    <= 3'd0;
            vsync_d_q <= 1'b0;
            anim_q    <= '0;
            step_q    <= 1'b0;
            ack_q     <= 1'b0;
            drop_q    <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < 5; i++) slot_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            sidx_q    <= sidx_d;
            vsync_d_q <= vsync_d_d;
            anim_q    <= anim_d;
            step_q    <= step_d;
            ack_q     <= ack_d;
            drop_q    <= drop_d;
            busy_q    <= busy_d;
            slot_q    <= slot_d;
        end
    end

    assign bus.spawn_ack  = ack_q;
    assign bus.spawn_drop = drop_q;
    assign bus.busy       = busy_q;
    assign bus.p_obj1     = slot_q[0];
    assign bus.p_obj2     = slot_q[1];
    assign bus.p_obj3     = slot_q[2];
    assign bus.p_obj4     = slot_q[3];
    assign bus.p_obj5     = slot_q[4];
endmodule

// File: tb/tb_obj_scheduler.sv
// Directed bench for obj_scheduler: spawn, full drop, scroll/retire, animation, collide, async reset.
module tb_obj_scheduler;
    logic       vclock = 1'b0;
    logic       reset_n = 1'b0;
    logic       vsync = 1'b1;
    logic [3:0] scroll_speed = 4'd0;
    int         checks = 0;
    int         errors = 0;

    obj_scheduler_if bus();

    obj_scheduler dut (
        .vclock       (vclock),
        .reset_n      (reset_n),
        .vsync        (vsync),
        .scroll_speed (scroll_speed),
        .bus          (bus)
    );

    always #5 vclock = ~vclock;

    function automatic logic [25:0] w(input logic [2:0] f, input logic [1:0] id,
                                      input logic [10:0] h, input logic [9:0] v);
        return {f, id, h, v};
    endfunction

    task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge vclock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        vsync = 1'b1;
        scroll_speed = 4'd0;
        bus.spawn_req = 1'b0;
        bus.spawn_type = 2'd0;
        bus.spawn_vpos = 10'd0;
        bus.collide = 5'd0;
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
    endtask

    task automatic spawn(input logic [1:0] t, input logic [9:0] v, input logic exp_drop);
        bus.spawn_req = 1'b1;
        bus.spawn_type = t;
        bus.spawn_vpos = v;
        step();
        check("spawn_ack", 26'(bus.spawn_ack), 26'd1);
        check("spawn_drop", 26'(bus.spawn_drop), 26'(exp_drop));
        bus.spawn_req = 1'b0;
        step();
        check("ack_clears", 26'(bus.spawn_ack), 26'd0);
    endtask

    task automatic frame_tick(input logic chk_busy);
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (chk_busy) check("busy_high", 26'(bus.busy), 26'd1);
            step();
        end
        if (chk_busy) check("busy_low", 26'(bus.busy), 26'd0);
    endtask

    initial begin
        bus.spawn_req = 1'b0;
        bus.spawn_type = 2'd0;
        bus.spawn_vpos = 10'd0;
        bus.collide = 5'd0;

        // 1: reset state and first spawn
        do_reset();
        check("rst_p_obj1", bus.p_obj1, 26'd0);
        check("rst_p_obj5", bus.p_obj5, 26'd0);
        check("rst_busy", 26'(bus.busy), 26'd0);
        spawn(2'd1, 10'd200, 1'b0);
        check("spawn1_word", bus.p_obj1, w(3'd0, 2'd1, 11'd1009, 10'd200));

        // 2: fill all slots, sixth request dropped
        spawn(2'd2, 10'd10, 1'b0);
        spawn(2'd3, 10'd20, 1'b0);
        spawn(2'd0, 10'd30, 1'b0);
        spawn(2'd1, 10'd40, 1'b0);
        check("fill_p_obj2", bus.p_obj2, w(3'd0, 2'd2, 11'd1009, 10'd10));
        check("fill_p_obj5", bus.p_obj5, w(3'd0, 2'd1, 11'd1009, 10'd40));
        spawn(2'd3, 10'd500, 1'b1);
        check("drop_p_obj1", bus.p_obj1, w(3'd0, 2'd1, 11'd1009, 10'd200));
        check("drop_p_obj3", bus.p_obj3, w(3'd0, 2'd3, 11'd1009, 10'd20));
        check("drop_p_obj4", bus.p_obj4, w(3'd0, 2'd0, 11'd1009, 10'd30));
        check("drop_p_obj5", bus.p_obj5, w(3'd0, 2'd1, 11'd1009, 10'd40));

        // 3: scrolling down to the left edge; hpos 4 at speed 4 retires
        do_reset();
        spawn(2'd2, 10'd100, 1'b0);
        scroll_speed = 4'd4;
        frame_tick(1'b1);
        check("scroll_1005", bus.p_obj1, w(3'd0, 2'd2, 11'd1005, 10'd100));
        scroll_speed = 4'd15;
        for (int k = 0; k < 66; k++) frame_tick(1'b0);
        check("scroll_15", 26'(bus.p_obj1[20:10]), 26'd15);
        scroll_speed = 4'd11;
        frame_tick(1'b0);
        check("scroll_4", 26'(bus.p_obj1[20:10]), 26'd4);
        scroll_speed = 4'd4;
        frame_tick(1'b0);
        check("retire_at_4", bus.p_obj1, 26'd0);

        // 4: animation every 4th tick, 0..5 then wrap
        do_reset();
        spawn(2'd3, 10'd300, 1'b0);
        scroll_speed = 4'd0;
        for (int k = 1; k <= 24; k++) begin
            frame_tick(1'b0);
            check("anim_frame", 26'(bus.p_obj1[25:23]), 26'((k / 4) % 6));
        end
        check("anim_final", bus.p_obj1, w(3'd0, 2'd3, 11'd1009, 10'd300));

        // 5: collide on slot 2 during its sweep; pending spawn lands there after IDLE
        do_reset();
        spawn(2'd0, 10'd1, 1'b0);
        spawn(2'd1, 10'd2, 1'b0);
        spawn(2'd2, 10'd3, 1'b0);
        scroll_speed = 4'd1;
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        bus.spawn_req = 1'b1;
        bus.spawn_type = 2'd3;
        bus.spawn_vpos = 10'd77;
        step();
        check("swp_no_ack", 26'(bus.spawn_ack), 26'd0);
        check("swp_slot0", bus.p_obj1, w(3'd0, 2'd0, 11'd1008, 10'd1));
        step();
        bus.collide = 5'b00100;
        step();
        bus.collide = 5'd0;
        check("collide_slot2", bus.p_obj3, 26'd0);
        check("collide_slot1", bus.p_obj2, w(3'd0, 2'd1, 11'd1008, 10'd2));
        step();
        step();
        check("swp_done_busy", 26'(bus.busy), 26'd0);
        check("swp_done_noack", 26'(bus.spawn_ack), 26'd0);
        step();
        check("late_ack", 26'(bus.spawn_ack), 26'd1);
        check("late_drop", 26'(bus.spawn_drop), 26'd0);
        check("late_slot2", bus.p_obj3, w(3'd0, 2'd3, 11'd1009, 10'd77));
        bus.spawn_req = 1'b0;
        step();

        // 6: async reset in the middle of a sweep
        do_reset();
        spawn(2'd1, 10'd5, 1'b0);
        spawn(2'd2, 10'd6, 1'b0);
        spawn(2'd3, 10'd7, 1'b0);
        scroll_speed = 4'd2;
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("arst_p_obj1", bus.p_obj1, 26'd0);
        check("arst_p_obj3", bus.p_obj3, 26'd0);
        check("arst_busy", 26'(bus.busy), 26'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        check("post_rst_busy", 26'(bus.busy), 26'd0);
        check("post_rst_p_obj2", bus.p_obj2, 26'd0);
        spawn(2'd0, 10'd9, 1'b0);
        frame_tick(1'b1);
        check("clean_sweep", bus.p_obj1, w(3'd0, 2'd0, 11'd1007, 10'd9));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
